// File: rtl/evt_idx2vec_pkg.sv
// Shared definitions for the event unit: ID width and FIFO occupancy-count sizing.
package event_unit_pkg;

  localparam int FIFO_DEPTH_DFLT = 4;

  typedef logic [$clog2(FIFO_DEPTH_DFLT):0] fifo_cnt_t;

  function automatic int evt_idx_w(input int nb_evt);
    return (nb_evt > 1) ? $clog2(nb_evt) : 1;
  endfunction

  // One extra bit so that a completely full FIFO is representable.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/evt_id_fifo.sv
// Register FIFO for event IDs: push/pop, registered occupancy count, full/empty flags.
module evt_id_fifo
  import event_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == {CNT_W{1'b0}});
    do_push  = push && !full;
    do_pop   = pop && !empty;
    pop_data = mem[rd_ptr];
  end

  // Storage array needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/evt_idx2vec.sv
// Event-index decoder: buffers binary event IDs, decodes them one-hot and accumulates
// them into a registered pending vector with clear-by-index, clear-all and sticky flags.
module evt_idx2vec
  import event_unit_pkg::*;
#(
  parameter int NB_EVT     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = evt_idx_w(NB_EVT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_valid_i,
  input  logic [IDX_W-1:0]  set_idx_i,
  output logic              set_ready_o,
  input  logic              clr_valid_i,
  input  logic [IDX_W-1:0]  clr_idx_i,
  input  logic              clr_all_i,
  output logic [NB_EVT-1:0] pending_o,
  output logic              any_pending_o,
  output logic              merged_o,
  output logic              err_idx_o,
  input  logic              flag_clr_i
);

  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [IDX_W-1:0]  head_idx;

  logic [NB_EVT-1:0] set_vec;
  logic [NB_EVT-1:0] clr_vec;
  logic [NB_EVT-1:0] pending_nxt;
  logic              pop_in_range;
  logic              clr_in_range;
  logic              merge_hit;
  logic              err_hit;

  // Ready depends only on the registered count; the head is drained every cycle.
  always_comb begin
    set_ready_o = (fifo_count < CNT_W'(FIFO_DEPTH));
    fifo_push   = set_valid_i && !fifo_full;
    fifo_pop    = !fifo_empty;
  end

  evt_id_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (IDX_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (fifo_push),
    .push_data (set_idx_i),
    .pop       (fifo_pop),
    .pop_data  (head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A drained bit survives both clears on the same cycle so no event is lost.
  always_comb begin
    set_vec      = {NB_EVT{1'b0}};
    clr_vec      = {NB_EVT{1'b0}};
    pop_in_range = fifo_pop && (32'(head_idx) < 32'(NB_EVT));
    clr_in_range = clr_valid_i && (32'(clr_idx_i) < 32'(NB_EVT));
    for (int i = 0; i < NB_EVT; i++) begin
      set_vec[i] = pop_in_range && (head_idx == IDX_W'(i));
      clr_vec[i] = clr_in_range && (clr_idx_i == IDX_W'(i));
    end
    pending_nxt = set_vec | (pending_o & ~clr_vec & ~{NB_EVT{clr_all_i}});
    merge_hit   = (|(set_vec & pending_o & ~clr_vec)) && !clr_all_i;
    err_hit     = (fifo_pop && !pop_in_range) || (clr_valid_i && !clr_in_range);
  end

  // Pending vector and sticky flags; a flag-setting event beats flag_clr_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_o     <= {NB_EVT{1'b0}};
      any_pending_o <= 1'b0;
      merged_o      <= 1'b0;
      err_idx_o     <= 1'b0;
    end else begin
      pending_o     <= pending_nxt;
      any_pending_o <= |pending_nxt;
      merged_o      <= merge_hit || (merged_o && !flag_clr_i);
      err_idx_o     <= err_hit || (err_idx_o && !flag_clr_i);
    end
  end

endmodule

// File: tb/tb_evt_idx2vec.sv
// Self-checking bench: a 32-event and a 24-event instance share one stimulus stream
// and are compared every cycle against a queue-based behavioural model.
module tb_evt_idx2vec;

  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       set_valid;
  logic [4:0] set_idx;
  logic       clr_valid;
  logic [4:0] clr_idx;
  logic       clr_all;
  logic       flag_clr;

  logic        ready32, any32, merged32, err32;
  logic [31:0] pend32;
  logic        ready24, any24, merged24, err24;
  logic [23:0] pend24;

  int n_checks;
  int n_fail;

  evt_idx2vec #(.NB_EVT(32), .FIFO_DEPTH(FIFO_DEPTH)) u32 (
    .clk_i(clk), .rst_i(rst),
    .set_valid_i(set_valid), .set_idx_i(set_idx), .set_ready_o(ready32),
    .clr_valid_i(clr_valid), .clr_idx_i(clr_idx), .clr_all_i(clr_all),
    .pending_o(pend32), .any_pending_o(any32), .merged_o(merged32),
    .err_idx_o(err32), .flag_clr_i(flag_clr)
  );

  evt_idx2vec #(.NB_EVT(24), .FIFO_DEPTH(FIFO_DEPTH)) u24 (
    .clk_i(clk), .rst_i(rst),
    .set_valid_i(set_valid), .set_idx_i(set_idx), .set_ready_o(ready24),
    .clr_valid_i(clr_valid), .clr_idx_i(clr_idx), .clr_all_i(clr_all),
    .pending_o(pend24), .any_pending_o(any24), .merged_o(merged24),
    .err_idx_o(err24), .flag_clr_i(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int          mq[$];
  logic [31:0] m_pend32, m_pend24;
  bit          m_mg32, m_mg24, m_er32, m_er24;
  bit          m_pop, m_acc;
  int          m_id;

  task automatic model_upd(input int nb, input bit pop, input int id,
                           inout logic [31:0] pend, inout bit mg, inout bit er);
    logic [31:0] nxt;
    bit s_mg;
    bit s_er;
    int ci;
    s_mg = 1'b0;
    s_er = 1'b0;
    ci   = int'(clr_idx);
    nxt  = clr_all ? 32'h0 : pend;
    if (clr_valid) begin
      if (ci < nb) nxt = nxt & ~(32'h1 << ci);
      else s_er = 1'b1;
    end
    if (pop) begin
      if (id >= nb) s_er = 1'b1;
      else begin
        if (((pend >> id) & 32'h1) != 32'h0 && !clr_all && !(clr_valid && ci == id))
          s_mg = 1'b1;
        nxt = nxt | (32'h1 << id);
      end
    end
    pend = nxt;
    mg   = s_mg || (mg && !flag_clr);
    er   = s_er || (er && !flag_clr);
  endtask

  initial begin
    m_pend32 = 32'h0; m_pend24 = 32'h0;
    m_mg32 = 1'b0; m_mg24 = 1'b0; m_er32 = 1'b0; m_er24 = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pend32 = 32'h0; m_pend24 = 32'h0;
      m_mg32 = 1'b0; m_mg24 = 1'b0; m_er32 = 1'b0; m_er24 = 1'b0;
    end else begin
      m_pop = (mq.size() != 0);
      m_acc = set_valid && (mq.size() < FIFO_DEPTH);
      m_id  = 0;
      if (m_pop) m_id = mq.pop_front();
      if (m_acc) mq.push_back(int'(set_idx));
      model_upd(32, m_pop, m_id, m_pend32, m_mg32, m_er32);
      model_upd(24, m_pop, m_id, m_pend24, m_mg24, m_er24);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready32", 32'(ready32), 32'(mq.size() < FIFO_DEPTH));
    chk("pend32", pend32, m_pend32);
    chk("any32", 32'(any32), 32'(m_pend32 != 32'h0));
    chk("merged32", 32'(merged32), 32'(m_mg32));
    chk("err32", 32'(err32), 32'(m_er32));
    chk("ready24", 32'(ready24), 32'(mq.size() < FIFO_DEPTH));
    chk("pend24", 32'(pend24), m_pend24);
    chk("any24", 32'(any24), 32'(m_pend24 != 32'h0));
    chk("merged24", 32'(merged24), 32'(m_mg24));
    chk("err24", 32'(err24), 32'(m_er24));
  end

  task automatic step(input logic sv, input logic [4:0] si, input logic cv,
                      input logic [4:0] ci, input logic ca, input logic fc);
    set_valid = sv; set_idx = si; clr_valid = cv; clr_idx = ci;
    clr_all = ca; flag_clr = fc;
    @(negedge clk);
    set_valid = 1'b0; set_idx = 5'd0; clr_valid = 1'b0; clr_idx = 5'd0;
    clr_all = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    set_valid = 1'b0; set_idx = 5'd0; clr_valid = 1'b0; clr_idx = 5'd0;
    clr_all = 1'b0; flag_clr = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready32), 32'h1);
    chk("rst_pend", pend32, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single push of ID 5: visible two cycles later
    chk("t1_ready", 32'(ready32), 32'h1);
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t1_pend_c1", pend32, 32'h0);
    idle();
    chk("t1_pend_c2", pend32, 32'h0000_0020);
    chk("t1_any_c2", 32'(any32), 32'h1);

    // Back-to-back IDs 0..5 drain without stalling
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t2_ready", 32'(ready32), 32'h1);
      step(1'b1, 5'(i), 1'b0, 5'd0, 1'b0, 1'b0);
    end
    idle();
    chk("t2_pend", pend32, 32'h0000_003F);

    // Duplicate ID 7 sets merged, flag_clr clears it
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    chk("t3_merged", 32'(merged32), 32'h1);
    chk("t3_pend", pend32, 32'h0000_0080);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("t3_merged_clr", 32'(merged32), 32'h0);

    // Drained bit 7 beats clr_valid(7) and clr_all; bit 1 is cleared
    step(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    idle();
    chk("t4_pre", pend32, 32'h0000_0082);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    chk("t4_pend", pend32, 32'h0000_0080);
    chk("t4_merged", 32'(merged32), 32'h0);

    // Out-of-range IDs on the 24-event instance
    step(1'b1, 5'd30, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    chk("t5_err24", 32'(err24), 32'h1);
    chk("t5_pend24", 32'(pend24), 32'h0000_0080);
    chk("t5_err32", 32'(err32), 32'h0);
    step(1'b0, 5'd0, 1'b1, 5'd31, 1'b0, 1'b0);
    chk("t5_err24_clr", 32'(err24), 32'h1);
    chk("t5_pend24_clr", 32'(pend24), 32'h0000_0080);
    chk("t5_pend32", pend32, 32'h4000_0080);

    // Reset mid-stream: asynchronous clear, buffered IDs discarded
    step(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 1'b0);
    set_valid = 1'b1; set_idx = 5'd11;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pend", pend32, 32'h0);
    chk("t6_async_any", 32'(any32), 32'h0);
    chk("t6_async_err24", 32'(err24), 32'h0);
    set_valid = 1'b0; set_idx = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    idle();
    idle();
    chk("t6_pend_after", pend32, 32'h0);
    chk("t6_ready_after", 32'(ready32), 32'h1);
    chk("t6_any_after", 32'(any32), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
